// File: rtl/uart_rx_8n1.sv
// uart_rx_8n1: 8N1 UART receiver running on the system clock.
// The rx line is double-flopped, the start bit is confirmed at mid-bit,
// data and stop bits are sampled one bit period apart from that point.
// Completed bytes are reported with a one-cycle rxvalid strobe; a low stop
// bit gives a one-cycle framing_err strobe, after which the receiver waits
// for the line to return high before looking for a new start bit.
module uart_rx_8n1 #(
  parameter int CLKS_PER_BIT = 1250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rxbyte,
  output logic       rxvalid,
  output logic       framing_err,
  output logic       busy
);

  // Counter only has to reach CLKS_PER_BIT-1.
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  state_t           state_r;
  logic             sync1_r;
  logic             rx_s;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       bit_idx_r;
  logic [7:0]       shift_r;

  // Two-flop synchronizer for the asynchronous rx pin; idles high.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      sync1_r <= rx;
      rx_s    <= sync1_r;
    end
  end

  // Receive FSM: bit timing, sampling, shift register and registered strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= CNT_ZERO;
      bit_idx_r   <= 3'd0;
      shift_r     <= 8'h00;
      rxbyte      <= 8'h00;
      rxvalid     <= 1'b0;
      framing_err <= 1'b0;
      busy        <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      rxvalid     <= 1'b0;
      framing_err <= 1'b0;
      case (state_r)
        IDLE: begin
          cnt_r <= CNT_ZERO;
          if (!rx_s) begin
            state_r <= START;
            busy    <= 1'b1;
          end
        end
        START: begin
          if (cnt_r == HALF_LAST) begin
            cnt_r <= CNT_ZERO;
            if (!rx_s) begin
              state_r   <= DATA;
              bit_idx_r <= 3'd0;
            end else begin
              // Low pulse shorter than half a bit: treat as a glitch.
              state_r <= IDLE;
              busy    <= 1'b0;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        DATA: begin
          if (cnt_r == FULL_LAST) begin
            cnt_r     <= CNT_ZERO;
            shift_r   <= {rx_s, shift_r[7:1]};
            bit_idx_r <= bit_idx_r + 3'd1;
            if (bit_idx_r == 3'd7) begin
              state_r <= STOP;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        STOP: begin
          if (cnt_r == FULL_LAST) begin
            cnt_r <= CNT_ZERO;
            if (rx_s) begin
              // Rearm at mid-stop-bit so back-to-back frames are caught.
              rxbyte  <= shift_r;
              rxvalid <= 1'b1;
              state_r <= IDLE;
              busy    <= 1'b0;
            end else begin
              framing_err <= 1'b1;
              state_r     <= WAIT_HIGH;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        WAIT_HIGH: begin
          // A held-low line (break) must not look like a new start bit.
          if (rx_s) begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= CNT_ZERO;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_8n1.sv
// tb_uart_rx_8n1: directed and random frames driven onto rx with real-time
// bit periods; received bytes and error strobes are compared against an
// expected-frame queue maintained by the bench.
module tb_uart_rx_8n1;

  localparam int CPB    = 16;
  localparam int CLK_NS = 10;
  localparam int BIT_NS = CPB * CLK_NS;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] rxbyte;
  logic       rxvalid;
  logic       framing_err;
  logic       busy;

  uart_rx_8n1 #(.CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .rxbyte      (rxbyte),
    .rxvalid     (rxvalid),
    .framing_err (framing_err),
    .busy        (busy)
  );

  // 100 MHz simulation clock (timing is expressed in clock counts).
  always #(CLK_NS / 2) clk = ~clk;

  int cyc = 0;
  // Free-running cycle counter used for latency and spacing measurements.
  always @(posedge clk) cyc <= cyc + 1;

  // Observed events.
  logic [7:0] got_q[$];
  int         got_cyc[$];
  int         fe_cnt    = 0;
  int         both_cnt  = 0;
  bit         busy_seen = 1'b0;

  // Reference model state.
  logic [7:0] exp_q[$];
  int         exp_fe    = 0;
  logic [7:0] last_good = 8'h00;

  int n_checks = 0;
  int n_fail   = 0;

  // Monitor: record output strobes on the falling edge, away from updates.
  always @(negedge clk) begin
    if (rxvalid) begin
      got_q.push_back(rxbyte);
      got_cyc.push_back(cyc);
    end
    if (framing_err) fe_cnt++;
    if (rxvalid && framing_err) both_cnt++;
    if (busy) busy_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Drive start bit, nbits data bits LSB first, and the stop bit if all 8 sent.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                            input int bit_ns, input int nbits);
    logic [7:0] dv;
    dv = d;
    rx = 1'b0;
    #(bit_ns);
    for (int i = 0; i < nbits; i++) begin
      rx = dv[i];
      #(bit_ns);
    end
    if (nbits == 8) begin
      rx = stop_bit;
      #(bit_ns);
    end
  endtask

  // Hold the line idle, then realign to just after a rising edge.
  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_frames(input string tag);
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      check({tag, "_byte"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
    end
    got_q.delete();
    exp_q.delete();
    got_cyc.delete();
    check({tag, "_ferr_count"}, 32'(fe_cnt), 32'(exp_fe));
    check({tag, "_rxbyte_hold"}, 32'(rxbyte), 32'(last_good));
  endtask

  task automatic good(input logic [7:0] b, input int bit_ns);
    exp_q.push_back(b);
    last_good = b;
    send_frame(b, 1'b1, bit_ns, 8);
  endtask

  initial begin
    int         t0;
    logic       lat_ok;
    logic [7:0] b;

    // Reset state.
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rxbyte", 32'(rxbyte), 32'h00);
    check("rst_rxvalid", 32'(rxvalid), 32'h0);
    check("rst_framing_err", 32'(framing_err), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    idle(20);

    // Single byte, with latency from the start-bit falling edge.
    t0 = cyc;
    good(8'h55, BIT_NS);
    idle(40);
    lat_ok = (got_cyc.size() == 1) && (got_cyc[0] - t0 >= 154) && (got_cyc[0] - t0 <= 156);
    check("single_latency_ok", 32'(lat_ok), 32'h1);
    check("single_busy_after", 32'(busy), 32'h0);
    check_frames("single");

    // Back-to-back frames with one stop bit and no idle gap.
    good(8'h00, BIT_NS);
    good(8'hFF, BIT_NS);
    good(8'hA5, BIT_NS);
    idle(40);
    check("b2b_pulses", 32'(got_cyc.size()), 32'd3);
    if (got_cyc.size() == 3) begin
      check("b2b_spacing_1", 32'(got_cyc[1] - got_cyc[0]), 32'd160);
      check("b2b_spacing_2", 32'(got_cyc[2] - got_cyc[1]), 32'd160);
    end
    check_frames("b2b");

    // Glitch shorter than half a bit, followed by a good frame.
    busy_seen = 1'b0;
    rx = 1'b0;
    #(5 * CLK_NS);
    idle(40);
    check("glitch_busy_pulsed", 32'(busy_seen), 32'h1);
    check("glitch_busy_after", 32'(busy), 32'h0);
    check_frames("glitch");
    good(8'h3C, BIT_NS);
    idle(40);
    check_frames("after_glitch");

    // Framing error, then a break, then recovery.
    good(8'h12, BIT_NS);
    send_frame(8'hA5, 1'b0, BIT_NS, 8);
    exp_fe++;
    #(40 * CLK_NS);
    idle(40);
    check_frames("framing");
    good(8'h7E, BIT_NS);
    idle(40);
    check_frames("after_break");

    // Reset mid-frame (middle of data bit 4 of 0xC3); line goes idle with it.
    send_frame(8'hC3, 1'b1, BIT_NS, 4);
    rx = 1'b0;
    #(BIT_NS / 2);
    check("midframe_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    rx  = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    last_good = 8'h00;
    check("midrst_rxbyte", 32'(rxbyte), 32'h00);
    check("midrst_rxvalid", 32'(rxvalid), 32'h0);
    check("midrst_framing_err", 32'(framing_err), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    idle(200);
    check_frames("midrst");
    good(8'h81, BIT_NS);
    idle(40);
    check_frames("after_rst");

    // Baud skew of about +/-3% (15.5 and 16.5 clocks per bit).
    good(8'h96, BIT_NS - CLK_NS / 2);
    idle(40);
    check_frames("skew_fast");
    good(8'h96, BIT_NS + CLK_NS / 2);
    idle(40);
    check_frames("skew_slow");

    // Random back-to-back bytes.
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom_range(0, 255));
      good(b, BIT_NS);
    end
    idle(40);
    check_frames("random");

    check("mutual_exclusion", 32'(both_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
